decrypt_seq_ctrl: RTL and testbench

Parametrised phase sequencer and shared-memory port arbiter for the ROLLO decryption datapath.
- Phase order: gf2mz multiply → iterated S1S2 generation / RSR elimination → optional SHA3.
- Adds over the previous fixed controller: configurable iteration count, runtime hash bypass, per-phase watchdog with error reporting, abort, and a configurable registered mux on the shared S1S2 memory ports.

---
 rtl/decrypt_seq_ctrl_pkg.sv | 25 ++
 rtl/decrypt_seq_ctrl_if.sv | 32 +++
 rtl/decrypt_seq_ctrl_mem_port_mux.sv | 57 +++++
 rtl/decrypt_seq_ctrl.sv | 158 +++++++++++++++
 tb/tb_decrypt_seq_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/decrypt_seq_ctrl_pkg.sv
// rtl/decrypt_seq_ctrl_pkg.sv - shared encodings and helpers for the ROLLO decryption sequencer
package decrypt_seq_ctrl_pkg;

   // State encoding doubles as the externally visible status code.
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_MUL  = 3'd1,
      ST_GEN  = 3'd2,
      ST_RSR  = 3'd3,
      ST_HASH = 3'd4,
      ST_DONE = 3'd5,
      ST_ERR  = 3'd6
   } state_t;

   localparam logic [2:0] ERR_NONE = 3'd0;
   localparam logic [2:0] ERR_MUL  = 3'd1;
   localparam logic [2:0] ERR_GEN  = 3'd2;
   localparam logic [2:0] ERR_RSR  = 3'd3;
   localparam logic [2:0] ERR_HASH = 3'd4;

   function automatic int iter_w(input int iter);
      return (iter > 1) ? $clog2(iter) : 1;
   endfunction

endpackage

// File: rtl/decrypt_seq_ctrl_if.sv
// rtl/decrypt_seq_ctrl_if.sv - engine handshake and shared S1S2 memory port bundle
interface decrypt_seq_ctrl_if #(
   parameter int AW = 9,
   parameter int DW = 16
) ();
   logic          mul_start, gen_start, rsr_start, hash_start;
   logic          mul_done, gen_done, rsr_done, hash_done;
   logic [AW-1:0] gen_addr, rsr_addra, rsr_addrb, hash_addr;
   logic          gen_we, rsr_wea, rsr_web, hash_we;
   logic [DW-1:0] gen_di, rsr_dia, rsr_dib;
   logic [AW-1:0] mem_addra, mem_addrb;
   logic          mem_wea, mem_web;
   logic [DW-1:0] mem_dia, mem_dib;

   modport master (
      output mul_start, gen_start, rsr_start, hash_start,
      input  mul_done, gen_done, rsr_done, hash_done,
      input  gen_addr, rsr_addra, rsr_addrb, hash_addr,
      input  gen_we, rsr_wea, rsr_web, hash_we,
      input  gen_di, rsr_dia, rsr_dib,
      output mem_addra, mem_addrb, mem_wea, mem_web, mem_dia, mem_dib
   );

   modport slave (
      input  mul_start, gen_start, rsr_start, hash_start,
      output mul_done, gen_done, rsr_done, hash_done,
      output gen_addr, rsr_addra, rsr_addrb, hash_addr,
      output gen_we, rsr_wea, rsr_web, hash_we,
      output gen_di, rsr_dia, rsr_dib,
      input  mem_addra, mem_addrb, mem_wea, mem_web, mem_dia, mem_dib
   );
endinterface

// File: rtl/decrypt_seq_ctrl_mem_port_mux.sv
// rtl/decrypt_seq_ctrl_mem_port_mux.sv - phase-selected, MEM_PIPE-deep registered mux onto the shared S1S2 ports
module mem_port_mux
   import decrypt_seq_ctrl_pkg::*;
#(
   parameter int AW       = 9,
   parameter int DW       = 16,
   parameter int MEM_PIPE = 2
) (
   input  logic          clk,
   input  logic          rst_b,
   input  state_t        sel,
   input  logic [AW-1:0] gen_addr,
   input  logic          gen_we,
   input  logic [DW-1:0] gen_di,
   input  logic [AW-1:0] rsr_addra,
   input  logic          rsr_wea,
   input  logic [DW-1:0] rsr_dia,
   input  logic [AW-1:0] rsr_addrb,
   input  logic          rsr_web,
   input  logic [DW-1:0] rsr_dib,
   input  logic [AW-1:0] hash_addr,
   output logic [AW-1:0] mem_addra,
   output logic          mem_wea,
   output logic [DW-1:0] mem_dia,
   output logic [AW-1:0] mem_addrb,
   output logic          mem_web,
   output logic [DW-1:0] mem_dib
);
   localparam int PORT_W = AW + 1 + DW;
   localparam int PW     = 2 * PORT_W;

   logic [PW-1:0] sel_w;
   logic [PW-1:0] pipe [MEM_PIPE];

   // addr, we and data travel together so a late request still lands intact.
   always_comb begin
      sel_w = '0;
      case (sel)
         ST_GEN:  sel_w = {gen_addr, gen_we, gen_di, {PORT_W{1'b0}}};
         ST_RSR:  sel_w = {rsr_addra, rsr_wea, rsr_dia, rsr_addrb, rsr_web, rsr_dib};
         ST_HASH: sel_w = {hash_addr, 1'b0, {DW{1'b0}}, {PORT_W{1'b0}}};
         default: sel_w = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         for (int i = 0; i < MEM_PIPE; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= sel_w;
         for (int i = 1; i < MEM_PIPE; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign {mem_addra, mem_wea, mem_dia, mem_addrb, mem_web, mem_dib} = pipe[MEM_PIPE-1];

endmodule

// File: rtl/decrypt_seq_ctrl.sv
// rtl/decrypt_seq_ctrl.sv - ROLLO decryption phase sequencer with watchdog, abort and shared-port mux
module decrypt_seq_ctrl
   import decrypt_seq_ctrl_pkg::*;
#(
   parameter int ITER     = 6,
   parameter int AW       = 9,
   parameter int M        = 8,
   parameter int DW       = 2*M,
   parameter int TMO_W    = 20,
   parameter int MEM_PIPE = 2
) (
   input  logic                    clk,
   input  logic                    rst_b,
   input  logic                    start,
   input  logic                    abort,
   input  logic                    hash_en,
   output logic                    busy,
   output logic                    finish,
   output logic                    err,
   output logic [2:0]              err_code,
   output logic [2:0]              status,
   output logic [iter_w(ITER)-1:0] iterate,
   output logic                    mat_sel,
   output logic                    is_last,
   decrypt_seq_ctrl_if.master      eng
);
   localparam int IW = iter_w(ITER);
   // One below all-ones: ERR is registered on the edge where the count would reach 2^TMO_W-1.
   localparam logic [TMO_W-1:0] WD_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

   state_t           state, next_state;
   logic [IW-1:0]    iter_q, iter_n;
   logic [TMO_W-1:0] wd;
   logic             hash_q, accept, tmo, last_round, in_phase;
   logic             mul_start_q, gen_start_q, rsr_start_q, hash_start_q;

   assign in_phase   = (state == ST_MUL) || (state == ST_GEN) ||
                       (state == ST_RSR) || (state == ST_HASH);
   assign accept     = start && !abort && ((state == ST_IDLE) || (state == ST_ERR));
   assign tmo        = in_phase && (wd == WD_LAST);
   assign last_round = (iter_q == IW'(ITER-2));

   // Done pulses are checked before tmo so a coincident done wins.
   always_comb begin
      next_state = state;
      iter_n     = iter_q;
      if (abort) begin
         next_state = ST_IDLE;
         iter_n     = '0;
      end else begin
         case (state)
            ST_IDLE, ST_ERR: begin
               if (start) begin
                  next_state = ST_MUL;
                  iter_n     = '0;
               end
            end
            ST_MUL: begin
               if (eng.mul_done) begin
                  next_state = ST_GEN;
                  iter_n     = '0;
               end else if (tmo) begin
                  next_state = ST_ERR;
               end
            end
            ST_GEN: begin
               if (eng.gen_done)  next_state = ST_RSR;
               else if (tmo)      next_state = ST_ERR;
            end
            ST_RSR: begin
               if (eng.rsr_done) begin
                  if (last_round) begin
                     next_state = hash_q ? ST_HASH : ST_DONE;
                  end else begin
                     next_state = ST_GEN;
                     iter_n     = iter_q + 1'b1;
                  end
               end else if (tmo) begin
                  next_state = ST_ERR;
               end
            end
            ST_HASH: begin
               if (eng.hash_done) next_state = ST_DONE;
               else if (tmo)      next_state = ST_ERR;
            end
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state        <= ST_IDLE;
         iter_q       <= '0;
         wd           <= '0;
         hash_q       <= 1'b0;
         err          <= 1'b0;
         err_code     <= ERR_NONE;
         mul_start_q  <= 1'b0;
         gen_start_q  <= 1'b0;
         rsr_start_q  <= 1'b0;
         hash_start_q <= 1'b0;
      end else begin
         state  <= next_state;
         iter_q <= iter_n;
         if ((next_state != state) || !in_phase) wd <= '0;
         else                                    wd <= wd + 1'b1;
         if (accept) hash_q <= hash_en;
         err <= (next_state == ST_ERR);
         if ((next_state == ST_ERR) && (state != ST_ERR)) err_code <= state;
         else if (accept || abort)                         err_code <= ERR_NONE;
         mul_start_q  <= (next_state == ST_MUL)  && (state != ST_MUL);
         gen_start_q  <= (next_state == ST_GEN)  && (state != ST_GEN);
         rsr_start_q  <= (next_state == ST_RSR)  && (state != ST_RSR);
         hash_start_q <= (next_state == ST_HASH) && (state != ST_HASH);
      end
   end

   assign eng.mul_start  = mul_start_q;
   assign eng.gen_start  = gen_start_q;
   assign eng.rsr_start  = rsr_start_q;
   assign eng.hash_start = hash_start_q;

   assign busy    = in_phase;
   assign finish  = (state == ST_DONE);
   assign status  = state;
   assign iterate = iter_q;
   assign mat_sel = |iter_q;
   assign is_last = last_round;

   mem_port_mux #(
      .AW       (AW),
      .DW       (DW),
      .MEM_PIPE (MEM_PIPE)
   ) u_mem_port_mux (
      .clk       (clk),
      .rst_b     (rst_b),
      .sel       (state),
      .gen_addr  (eng.gen_addr),
      .gen_we    (eng.gen_we),
      .gen_di    (eng.gen_di),
      .rsr_addra (eng.rsr_addra),
      .rsr_wea   (eng.rsr_wea),
      .rsr_dia   (eng.rsr_dia),
      .rsr_addrb (eng.rsr_addrb),
      .rsr_web   (eng.rsr_web),
      .rsr_dib   (eng.rsr_dib),
      .hash_addr (eng.hash_addr),
      .mem_addra (eng.mem_addra),
      .mem_wea   (eng.mem_wea),
      .mem_dia   (eng.mem_dia),
      .mem_addrb (eng.mem_addrb),
      .mem_web   (eng.mem_web),
      .mem_dib   (eng.mem_dib)
   );

endmodule

// File: tb/tb_decrypt_seq_ctrl.sv
// tb/tb_decrypt_seq_ctrl.sv - self-checking bench for decrypt_seq_ctrl (ITER=4, TMO_W=4, MEM_PIPE=2)
module tb_decrypt_seq_ctrl;
   import decrypt_seq_ctrl_pkg::*;

   localparam int AW = 9;
   localparam int DW = 16;
   localparam int IW = 2;

   logic clk = 1'b0;
   logic rst_b = 1'b0;
   logic start = 1'b0, abort = 1'b0, hash_en = 1'b0;
   logic busy, finish, err, mat_sel, is_last;
   logic [2:0] err_code, status;
   logic [IW-1:0] iterate;
   logic [3:0] a_done = 4'b0;
   logic [3:0] m_done = 4'b0;

   decrypt_seq_ctrl_if #(.AW(AW), .DW(DW)) eng ();

   assign eng.mul_done  = a_done[0] | m_done[0];
   assign eng.gen_done  = a_done[1] | m_done[1];
   assign eng.rsr_done  = a_done[2] | m_done[2];
   assign eng.hash_done = a_done[3] | m_done[3];

   decrypt_seq_ctrl #(
      .ITER (4), .AW (AW), .M (8), .DW (DW), .TMO_W (4), .MEM_PIPE (2)
   ) dut (
      .clk (clk), .rst_b (rst_b), .start (start), .abort (abort), .hash_en (hash_en),
      .busy (busy), .finish (finish), .err (err), .err_code (err_code), .status (status),
      .iterate (iterate), .mat_sel (mat_sel), .is_last (is_last), .eng (eng)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  phase;
      logic [8:0]  ga;  logic gw;  logic [15:0] gd;
      logic [8:0]  ra;  logic rwa; logic [15:0] rda;
      logic [8:0]  rb;  logic rwb; logic [15:0] rdb;
      logic [8:0]  ha;  logic hw;
      logic [51:0] exp;
   } vec_t;
   typedef struct { logic [2:0] st; logic [IW-1:0] it; } sb_t;
   typedef struct { int due; logic [63:0] val; } mx_t;

   vec_t vec [7];
   sb_t  sq [$];
   mx_t  mq [$];
   int   checks = 0, failures = 0, cyc = 0;
   int   cd [4], n_start [4], ent_cyc [8];
   bit   en [4];
   int   n_finish, wide;
   logic [2:0] prev_st = 3'd0;
   logic [3:0] prev_pulse = 4'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] mem_now();
      return 64'({eng.mem_addra, eng.mem_wea, eng.mem_dia, eng.mem_addrb, eng.mem_web, eng.mem_dib});
   endfunction

   function automatic logic [63:0] counts();
      return 64'({8'(n_start[0]), 8'(n_start[1]), 8'(n_start[2]), 8'(n_start[3]), 8'(n_finish), 8'(wide)});
   endfunction

   task automatic tick();
      logic [3:0] p;
      sb_t e;
      mx_t t;
      @(negedge clk);
      cyc++;
      p = {eng.hash_start, eng.rsr_start, eng.gen_start, eng.mul_start};
      for (int k = 0; k < 4; k++) begin
         if (p[k]) begin
            n_start[k]++;
            if (prev_pulse[k]) wide++;
            chk("start_on_entry", 64'({status != prev_st, status}), 64'({1'b1, 3'(k+1)}));
         end
      end
      prev_pulse = p;
      if (finish) n_finish++;
      if (status != prev_st) begin
         ent_cyc[status] = cyc;
         if (sq.size() == 0) begin
            chk("unexpected_state", 64'(status), 64'(prev_st));
         end else begin
            e = sq.pop_front();
            chk("state_seq", 64'({status, iterate, is_last, mat_sel, busy}),
                64'({e.st, e.it, e.it == IW'(2), e.it != '0, (e.st >= 3'd1) && (e.st <= 3'd4)}));
         end
         prev_st = status;
      end
      while (mq.size() > 0 && mq[0].due == cyc) begin
         t = mq.pop_front();
         chk("mem_port", mem_now(), t.val);
      end
      a_done = 4'b0;
      for (int k = 0; k < 4; k++) begin
         if (p[k]) cd[k] = 5;
         else if (cd[k] > 0) begin
            cd[k]--;
            if (cd[k] == 0 && en[k]) a_done[k] = 1'b1;
         end
      end
   endtask

   task automatic wait_st(input logic [2:0] st, input int budget);
      int n = 0;
      do begin
         tick();
         n++;
      end while (status != st && n < budget);
      chk("wait_state", 64'(status), 64'(st));
   endtask

   task automatic new_run();
      for (int k = 0; k < 4; k++) begin
         n_start[k] = 0; cd[k] = 0; en[k] = 1'b1;
      end
      n_finish = 0;
      wide = 0;
   endtask

   task automatic ex(input logic [2:0] st, input int it);
      sb_t e;
      e.st = st;
      e.it = IW'(it);
      sq.push_back(e);
   endtask

   task automatic clr_req();
      eng.gen_addr = '0; eng.gen_we = 1'b0; eng.gen_di = '0;
      eng.rsr_addra = '0; eng.rsr_wea = 1'b0; eng.rsr_dia = '0;
      eng.rsr_addrb = '0; eng.rsr_web = 1'b0; eng.rsr_dib = '0;
      eng.hash_addr = '0; eng.hash_we = 1'b0;
   endtask

   task automatic kick(input logic h);
      hash_en = h;
      start = 1'b1;
      tick();
      start = 1'b0;
      hash_en = ~h;
   endtask

   initial begin
      mx_t t;
      int  n;
      vec[0] = '{ST_MUL,  9'h055, 1'b1, 16'hAAAA, 9'h1A3, 1'b1, 16'h1234, 9'h0F0, 1'b1, 16'h5678, 9'h011, 1'b1, 52'h0};
      vec[1] = '{ST_GEN,  9'h155, 1'b1, 16'hBEEF, 9'h0AA, 1'b1, 16'h1111, 9'h0BB, 1'b1, 16'h2222, 9'h0CC, 1'b1,
                 {9'h155, 1'b1, 16'hBEEF, 26'h0}};
      vec[2] = '{ST_RSR,  9'h033, 1'b1, 16'h3333, 9'h1A3, 1'b1, 16'hC0DE, 9'h0F0, 1'b1, 16'h5A5A, 9'h044, 1'b1,
                 {9'h1A3, 1'b1, 16'hC0DE, 9'h0F0, 1'b1, 16'h5A5A}};
      vec[3] = '{ST_RSR,  9'h066, 1'b1, 16'h6666, 9'h002, 1'b0, 16'h0001, 9'h1FF, 1'b0, 16'hFFFF, 9'h077, 1'b0,
                 {9'h002, 1'b0, 16'h0001, 9'h1FF, 1'b0, 16'hFFFF}};
      vec[4] = '{ST_HASH, 9'h088, 1'b1, 16'h8888, 9'h099, 1'b1, 16'h9999, 9'h0AB, 1'b1, 16'hABAB, 9'h0C3, 1'b1,
                 {9'h0C3, 1'b0, 16'h0, 26'h0}};
      vec[5] = '{ST_DONE, 9'h1FF, 1'b1, 16'hFFFF, 9'h1FF, 1'b1, 16'hFFFF, 9'h1FF, 1'b1, 16'hFFFF, 9'h1FF, 1'b1, 52'h0};
      vec[6] = '{ST_IDLE, 9'h1FF, 1'b1, 16'hFFFF, 9'h1FF, 1'b1, 16'hFFFF, 9'h1FF, 1'b1, 16'hFFFF, 9'h1FF, 1'b1, 52'h0};
      clr_req();
      new_run();

      repeat (2) @(negedge clk);
      chk("rst_status", 64'(status), 64'(0));
      chk("rst_flags", 64'({busy, finish, err, err_code, iterate, mat_sel, is_last}), 64'(0));
      chk("rst_starts", 64'({eng.mul_start, eng.gen_start, eng.rsr_start, eng.hash_start}), 64'(0));
      chk("rst_mem", mem_now(), 64'(0));
      rst_b = 1'b1;

      // Nominal run with hash, port-mux vectors applied along the way.
      new_run();
      ex(1,0); ex(2,0); ex(3,0); ex(2,1); ex(3,1); ex(2,2); ex(3,2); ex(4,2); ex(5,2); ex(0,2);
      kick(1'b1);
      for (int i = 0; i < 7; i++) begin
         wait_st(vec[i].phase, 200);
         eng.gen_addr = vec[i].ga;  eng.gen_we = vec[i].gw;   eng.gen_di = vec[i].gd;
         eng.rsr_addra = vec[i].ra; eng.rsr_wea = vec[i].rwa; eng.rsr_dia = vec[i].rda;
         eng.rsr_addrb = vec[i].rb; eng.rsr_web = vec[i].rwb; eng.rsr_dib = vec[i].rdb;
         eng.hash_addr = vec[i].ha; eng.hash_we = vec[i].hw;
         t.due = cyc + 2;
         t.val = 64'(vec[i].exp);
         mq.push_back(t);
         tick();
         clr_req();
      end
      repeat (3) tick();
      chk("mem_sb_drained", 64'(mq.size()), 64'(0));
      chk("nom_sb_drained", 64'(sq.size()), 64'(0));
      chk("nom_counts", counts(), 64'({8'd1, 8'd3, 8'd3, 8'd1, 8'd1, 8'd0}));

      // Hash bypass, plus a stray hash_done and start while in GEN.
      new_run();
      ex(1,0); ex(2,0); ex(3,0); ex(2,1); ex(3,1); ex(2,2); ex(3,2); ex(5,2); ex(0,2);
      kick(1'b0);
      wait_st(ST_GEN, 50);
      m_done[3] = 1'b1;
      start = 1'b1;
      tick();
      m_done = 4'b0;
      start = 1'b0;
      chk("spurious_hold", 64'(status), 64'(ST_GEN));
      wait_st(ST_IDLE, 300);
      chk("bypass_sb_drained", 64'(sq.size()), 64'(0));
      chk("bypass_counts", counts(), 64'({8'd1, 8'd3, 8'd3, 8'd0, 8'd1, 8'd0}));

      // Watchdog timeout in RSR, then restart from ERR and abort.
      new_run();
      en[2] = 1'b0;
      ex(1,0); ex(2,0); ex(3,0); ex(6,0);
      kick(1'b1);
      wait_st(ST_ERR, 100);
      chk("tmo_latency", 64'(ent_cyc[6] - ent_cyc[3]), 64'(15));
      chk("err_state", 64'({err, err_code, busy}), 64'({1'b1, 3'd3, 1'b0}));
      en[2] = 1'b1;
      ex(1,0);
      kick(1'b1);
      chk("restart", 64'({status, err, err_code}), 64'({3'd1, 1'b0, 3'd0}));
      ex(0,0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_mul", 64'({status, busy}), 64'(0));
      chk("tmo_sb_drained", 64'(sq.size()), 64'(0));

      // Abort coincident with rsr_done at iterate 1.
      new_run();
      ex(1,0); ex(2,0); ex(3,0); ex(2,1); ex(3,1); ex(0,0);
      kick(1'b1);
      n = 0;
      do begin
         tick();
         n++;
      end while (!(status == ST_RSR && iterate == 2'd1) && n < 200);
      chk("reach_rsr1", 64'({status, iterate}), 64'({3'd3, 2'd1}));
      en[2] = 1'b0;
      repeat (2) tick();
      m_done[2] = 1'b1;
      abort = 1'b1;
      tick();
      m_done = 4'b0;
      abort = 1'b0;
      chk("abort_out", 64'({status, iterate, finish, eng.gen_start, eng.hash_start, busy}), 64'(0));
      repeat (3) tick();
      chk("abort_sb_drained", 64'(sq.size()), 64'(0));
      chk("abort_counts", counts(), 64'({8'd1, 8'd2, 8'd2, 8'd0, 8'd0, 8'd0}));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
